// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: immediate format selector and base opcodes.
package riscv_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } immsrc_t;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    // Scatter the immediate into its format-specific bit positions; every
    // bit outside those positions is copied from the base instruction.
    function automatic logic [31:0] pack_imm(input immsrc_t src,
                                             input logic [31:0] imm,
                                             input logic [31:0] base);
        logic [31:0] r;
        r = base;
        case (src)
            IMM_I: r[31:20] = imm[11:0];
            IMM_S: begin
                r[31:25] = imm[11:5];
                r[11:7]  = imm[4:0];
            end
            IMM_B: begin
                r[31]    = imm[12];
                r[30:25] = imm[10:5];
                r[11:8]  = imm[4:1];
                r[7]     = imm[11];
            end
            default: begin
                r[31]    = imm[20];
                r[30:21] = imm[10:1];
                r[20]    = imm[11];
                r[19:12] = imm[19:12];
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imm_range_chk.sv
// Combinational range check: flags an immediate that the selected format
// cannot represent (upper bits not a pure sign extension, or odd offset for
// branch/jump formats).
import riscv_pkg::*;

module imm_range_chk (
    input  logic [1:0]  immsrc,
    input  logic [31:0] imm,
    output logic        err
);

    logic sext_11;
    logic sext_12;
    logic sext_20;
    logic unused_mid;

    assign sext_11 = (&imm[31:11]) | ~(|imm[31:11]);
    assign sext_12 = (&imm[31:12]) | ~(|imm[31:12]);
    assign sext_20 = (&imm[31:20]) | ~(|imm[31:20]);
    // Middle bits always fit; they only matter for packing.
    assign unused_mid = ^imm[10:1];

    // Select the check that matches the requested format.
    always_comb begin
        err = 1'b0;
        case (immsrc_t'(immsrc))
            IMM_I, IMM_S: err = ~sext_11;
            IMM_B:        err = ~sext_12 | imm[0];
            default:      err = ~sext_20 | imm[0];
        endcase
    end

endmodule

// File: rtl/imm_encode.sv
// Immediate encoder: packs a signed immediate into an instruction word with
// a one-deep valid/ready output register and a range-check error flag.
// Optional saturating error counter enabled by IMM_ENCODE_ERRCNT_EN.
import riscv_pkg::*;

module imm_encode (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  immsrc,
    input  logic [31:0] imm,
    input  logic [31:0] base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err
`ifdef IMM_ENCODE_ERRCNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    logic        accept;
    logic        chk_err;
    logic [31:0] packed_word;

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;

    imm_range_chk u_chk (
        .immsrc (immsrc),
        .imm    (imm),
        .err    (chk_err)
    );

    // The register can take a new word when empty or when it drains this cycle.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign packed_word = pack_imm(immsrc_t'(immsrc), imm, base);

    // Next state: load on accept, clear on drain, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        err_d   = err_q;
        if (accept) begin
            valid_d = 1'b1;
            instr_d = packed_word;
            err_d   = chk_err;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign instr     = instr_q;
    assign err       = err_q;

`ifdef IMM_ENCODE_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Count accepted out-of-range requests, sticking at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && chk_err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= 16'h0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_imm_encode.sv
// Self-checking bench for imm_encode: directed vectors, backpressure,
// randomized traffic against a reference model, and reset mid-transfer.
module tb_imm_encode;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  immsrc;
    logic [31:0] imm;
    logic [31:0] base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
`ifdef IMM_ENCODE_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    int n_tests;
    int n_fail;
    int exp_cnt;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [31:0] imm;
        logic [1:0]  src;
    } exp_t;

    exp_t sb[$];

    imm_encode dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .immsrc    (immsrc),
        .imm       (imm),
        .base      (base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .err       (err)
`ifdef IMM_ENCODE_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: representable iff the signed value lies within the
    // format's range (and is even for branch/jump offsets).
    function automatic logic ref_err(input logic [1:0] src, input logic [31:0] v_in);
        longint v;
        longint lim;
        logic   need_even;
        v = longint'($signed(v_in));
        case (src)
            2'b10:   begin lim = 64'sd4096;    need_even = 1'b1; end
            2'b11:   begin lim = 64'sd1048576; need_even = 1'b1; end
            default: begin lim = 64'sd2048;    need_even = 1'b0; end
        endcase
        return (v < -lim) || (v > lim - 1) || (need_even && v_in[0]);
    endfunction

    // Reference packing taken field by field from the format tables.
    function automatic logic [31:0] ref_pack(input logic [1:0] src, input logic [31:0] v,
                                             input logic [31:0] b);
        logic [31:0] r;
        r = b;
        case (src)
            2'b00: r[31:20] = v[11:0];
            2'b01: begin r[31:25] = v[11:5]; r[11:7] = v[4:0]; end
            2'b10: begin r[31] = v[12]; r[30:25] = v[10:5]; r[11:8] = v[4:1]; r[7] = v[11]; end
            default: begin r[31] = v[20]; r[30:21] = v[10:1]; r[20] = v[11]; r[19:12] = v[19:12]; end
        endcase
        return r;
    endfunction

    // Standard RISC-V immediate extraction, used to check round-tripping.
    function automatic logic [31:0] decode(input logic [1:0] src, input logic [31:0] i);
        case (src)
            2'b00:   return {{20{i[31]}}, i[31:20]};
            2'b01:   return {{20{i[31]}}, i[31:25], i[11:7]};
            2'b10:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    function automatic logic [31:0] gen_imm(input logic [1:0] src);
        int lim;
        int v;
        lim = (src == 2'b10) ? 4096 : (src == 2'b11) ? (1 << 20) : 2048;
        case ($urandom_range(0, 6))
            0: v = lim - 1;
            1: v = lim;
            2: v = -lim;
            3: v = -lim - 1;
            4: v = lim - 2;
            5: v = int'($urandom_range(0, 2 * lim - 1)) - lim;
            default: v = int'($urandom);
        endcase
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        immsrc = 2'b00; imm = 32'h0; base = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || instr !== 32'h0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b instr=%h err=%b, required 0/00000000/0",
                     out_valid, instr, err);
        end
`ifdef IMM_ENCODE_ERRCNT_EN
        n_tests++;
        if (err_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_cnt: err_cnt=%h, required 0000", err_cnt);
        end
`endif
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_directed();
        logic [1:0]  v_src[7]  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b00};
        logic [31:0] v_base[7] = '{32'h00000093, 32'h0020A023, 32'h00000063, 32'h000000EF,
                                   32'h000000EF, 32'h00000063, 32'h00000093};
        logic [31:0] v_imm[7]  = '{32'hFFFFFFFF, 32'd8, 32'd8, 32'd4, 32'h00100000, 32'd3, 32'd2048};
        logic [31:0] v_exp[7]  = '{32'hFFF00093, 32'h0020A423, 32'h00000463, 32'h004000EF,
                                   32'h0, 32'h0, 32'h0};
        logic        v_err[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; out_ready = 1'b1;
            immsrc = v_src[k]; imm = v_imm[k]; base = v_base[k];
            @(posedge clk); #1 in_valid = 1'b0;
            if (v_err[k]) exp_cnt++;
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || err !== v_err[k] ||
                (!v_err[k] && instr !== v_exp[k])) begin
                n_fail++;
                $display("FAIL directed_%0d: valid=%b instr=%h err=%b, required 1/%h/%b",
                         k, out_valid, instr, err, v_exp[k], v_err[k]);
            end
`ifdef IMM_ENCODE_ERRCNT_EN
            n_tests++;
            if (err_cnt !== 16'(exp_cnt)) begin
                n_fail++;
                $display("FAIL directed_cnt_%0d: err_cnt=%0d, required %0d", k, err_cnt, exp_cnt);
            end
`endif
            $display("[TB] directed %0d src=%0d imm=%h instr=%h err=%b", k, v_src[k], v_imm[k], instr, err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  s[10];
        logic [31:0] m[10];
        logic [31:0] b[10];
        for (int k = 0; k < 10; k++) begin
            s[k] = 2'($urandom_range(0, 3)); m[k] = gen_imm(s[k]); b[k] = $urandom;
            if (ref_err(s[k], m[k])) exp_cnt++;
        end
        // Request 0 fills the register while the consumer stalls.
        in_valid = 1'b1; out_ready = 1'b0;
        immsrc = s[0]; imm = m[0]; base = b[0];
        @(posedge clk); #1;
        immsrc = s[1]; imm = m[1]; base = b[1];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || instr !== ref_pack(s[0], m[0], b[0]) ||
                err !== ref_err(s[0], m[0])) begin
                n_fail++;
                $display("FAIL stall_%0d: valid=%b ready=%b instr=%h err=%b, required 1/0/%h/%b",
                         c, out_valid, in_ready, instr, err, ref_pack(s[0], m[0], b[0]), ref_err(s[0], m[0]));
            end
            $display("[TB] stall cycle %0d instr=%h in_ready=%b", c, instr, in_ready);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        // Each following cycle shows the previous request; none may be lost.
        for (int k = 1; k < 10; k++) begin
            @(posedge clk); #1;
            if (k + 1 < 10) begin
                immsrc = s[k + 1]; imm = m[k + 1]; base = b[k + 1];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || instr !== ref_pack(s[k], m[k], b[k]) || err !== ref_err(s[k], m[k])) begin
                n_fail++;
                $display("FAIL stream_%0d: valid=%b instr=%h err=%b, required 1/%h/%b",
                         k, out_valid, instr, err, ref_pack(s[k], m[k], b[k]), ref_err(s[k], m[k]));
            end
            $display("[TB] stream %0d instr=%h err=%b", k, instr, err);
        end
`ifdef IMM_ENCODE_ERRCNT_EN
        n_tests++;
        if (err_cnt !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL stream_cnt: err_cnt=%0d, required %0d", err_cnt, exp_cnt);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        exp_t e;
        logic exp_rdy;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            immsrc = 2'($urandom_range(0, 3));
            imm    = gen_imm(immsrc);
            base   = $urandom;
            @(negedge clk);
            exp_rdy = (sb.size() == 0) || out_ready;
            n_tests++;
            if (out_valid !== (sb.size() != 0) || in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rand_hs_%0d: valid=%b ready=%b, required %b/%b",
                         c, out_valid, in_ready, sb.size() != 0, exp_rdy);
            end
            if (sb.size() != 0) begin
                e = sb[0];
                n_tests++;
                if (instr !== e.instr || err !== e.err) begin
                    n_fail++;
                    $display("FAIL rand_data_%0d: instr=%h err=%b, required %h/%b", c, instr, err, e.instr, e.err);
                end
                if (!e.err) begin
                    n_tests++;
                    if (decode(e.src, instr) !== e.imm) begin
                        n_fail++;
                        $display("FAIL rand_decode_%0d: decoded=%h, required %h", c, decode(e.src, instr), e.imm);
                    end
                end
                $display("[TB] rand %0d src=%0d imm=%h instr=%h err=%b", c, e.src, e.imm, instr, err);
                if (out_ready) void'(sb.pop_front());
            end
            if (in_valid && exp_rdy) begin
                e.src = immsrc; e.imm = imm;
                e.instr = ref_pack(immsrc, imm, base);
                e.err = ref_err(immsrc, imm);
                if (e.err) exp_cnt++;
                sb.push_back(e);
            end
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        sb.delete();
`ifdef IMM_ENCODE_ERRCNT_EN
        @(negedge clk);
        n_tests++;
        if (err_cnt !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL rand_cnt: err_cnt=%0d, required %0d", err_cnt, exp_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 1'b0;
        immsrc = 2'b00; imm = 32'd2048; base = 32'h00000093;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_load: valid=%b err=%b, required 1/1", out_valid, err);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || instr !== 32'h0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b instr=%h err=%b, required 0/00000000/0", out_valid, instr, err);
        end
`ifdef IMM_ENCODE_ERRCNT_EN
        n_tests++;
        if (err_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_reset_cnt: err_cnt=%0d, required 0", err_cnt);
        end
`endif
        exp_cnt = 0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after: ready=%b valid=%b, required 1/0", in_ready, out_valid);
        end
        $display("[TB] reset mid-transfer checked");
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_cnt = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
